pci_arbiter: RTL and testbench

- Central PCI bus arbiter for up to 8 bus-master slots in a simbus PCI simulation.
- Samples each master's REQ_n and drives that master's GNT_n.
- Tracks bus idle/busy from FRAME_n/IRDY_n.
- Shares the bus round-robin, parks the bus on a fixed slot when nobody requests, and revokes a grant that is never used.

---
 rtl/pci_arbiter.sv | 138 +++++++++++++
 tb/tb_pci_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant sharing, bus parking on a fixed slot,
// and revocation of grants that are never used. Every grant change passes through DEAD.
module pci_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned PARK          = 0,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic            PCI_CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ_n,
  output logic [NREQ-1:0] GNT_n,
  input  logic            FRAME_n,
  input  logic            IRDY_n,
  output logic [2:0]      OWNER,
  output logic            BUS_IDLE,
  output logic            TIMEOUT_PULSE
);

  localparam int unsigned OW = 3;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_DEAD,
    ST_GRANT,
    ST_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              revoked_q, revoked_d;
  logic              pulse_d;
  logic [NREQ-1:0]   gnt_n_d;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   owner_mask;
  logic              idle;
  logic              owner_req;
  logic              other_req;
  logic [OW-1:0]     winner;
  logic              found;
  int unsigned       idx;

  assign req        = ~REQ_n;
  assign idle       = FRAME_n & IRDY_n;
  assign owner_mask = NREQ'(1) << OWNER;
  assign owner_req  = |(req & owner_mask);
  assign other_req  = |(req & ~owner_mask);

  // Round-robin scan starting just after the pointer; the last owner has lowest priority
  always_comb begin
    winner = OW'(PARK);
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Next-state, bookkeeping and registered-output values
  always_comb begin
    state_d   = state_q;
    owner_d   = OWNER;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    revoked_d = revoked_q;
    pulse_d   = 1'b0;
    gnt_n_d   = '1;

    case (state_q)
      ST_DEAD: begin
        state_d   = ST_GRANT;
        owner_d   = winner;
        ptr_d     = winner;
        cnt_d     = '0;
        revoked_d = 1'b0;
      end
      ST_GRANT: begin
        if (!FRAME_n) begin
          state_d = ST_BUSY;
        end else if (idle && !owner_req && (winner != OWNER)) begin
          state_d = ST_DEAD;
        end else if (idle && owner_req && (cnt_q >= TO_LAST)) begin
          state_d = ST_DEAD;
          pulse_d = 1'b1;
          ptr_d   = OWNER;
        end else if (idle && (cnt_q < TO_LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BUSY: begin
        // Pulling GNT# lets the master's latency timer end the burst early
        if (idle) begin
          state_d = ST_DEAD;
        end else if (other_req) begin
          revoked_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_DEAD;
      end
    endcase

    if ((state_d == ST_GRANT) || ((state_d == ST_BUSY) && !revoked_d)) begin
      gnt_n_d = ~(NREQ'(1) << owner_d);
    end
  end

  always_ff @(posedge PCI_CLK) begin
    if (RESET) begin
      state_q       <= ST_DEAD;
      OWNER         <= OW'(PARK);
      ptr_q         <= OW'(PARK);
      cnt_q         <= '0;
      revoked_q     <= 1'b0;
      GNT_n         <= '1;
      BUS_IDLE      <= 1'b1;
      TIMEOUT_PULSE <= 1'b0;
    end else begin
      state_q       <= state_d;
      OWNER         <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      revoked_q     <= revoked_d;
      GNT_n         <= gnt_n_d;
      BUS_IDLE      <= idle;
      TIMEOUT_PULSE <= pulse_d;
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (NREQ=4, PARK=0, START_TIMEOUT=16): vector table plus
// hand-written round-robin, timeout and timeout-vs-FRAME sequences.
module tb_pci_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_n;
  logic [3:0] gnt_n;
  logic       frame_n;
  logic       irdy_n;
  logic [2:0] owner;
  logic       bus_idle;
  logic       to_pulse;

  int checks = 0;
  int errors = 0;

  pci_arbiter #(.NREQ(4), .PARK(0), .START_TIMEOUT(16)) dut (
    .PCI_CLK       (clk),
    .RESET         (rst),
    .REQ_n         (req_n),
    .GNT_n         (gnt_n),
    .FRAME_n       (frame_n),
    .IRDY_n        (irdy_n),
    .OWNER         (owner),
    .BUS_IDLE      (bus_idle),
    .TIMEOUT_PULSE (to_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [2:0] owner;
    logic       idle;
    logic       pulse;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic r, input logic [3:0] rq, input logic f, input logic ir,
                               input logic [3:0] g, input logic [2:0] o, input logic i, input logic p);
    vec_t v;
    v.rst = r; v.req_n = rq; v.frame_n = f; v.irdy_n = ir;
    v.gnt_n = g; v.owner = o; v.idle = i; v.pulse = p;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [3:0] rq, input logic f, input logic ir);
    rst = r; req_n = rq; frame_n = f; irdy_n = ir;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [2:0] eo,
                       input logic ei, input logic ep);
    checks++;
    if ({gnt_n, owner, bus_idle, to_pulse} !== {eg, eo, ei, ep}) begin
      errors++;
      $display("FAIL %s: got gnt_n=%b owner=%0d idle=%b pulse=%b, want gnt_n=%b owner=%0d idle=%b pulse=%b",
               name, gnt_n, owner, bus_idle, to_pulse, eg, eo, ei, ep);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].rst, tbl[i].req_n, tbl[i].frame_n, tbl[i].irdy_n);
      step();
      check($sformatf("row%0d", i), tbl[i].gnt_n, tbl[i].owner, tbl[i].idle, tbl[i].pulse);
    end
  endtask

  initial begin
    int          order[5];
    logic [3:0]  one;
    logic [3:0]  eg;

    drive(1'b1, 4'b1111, 1'b1, 1'b1);

    // reset, park, single request from park, return to park
    tbl.push_back(row(1, 4'b1111, 1, 1, 4'b1111, 0, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));
    tbl.push_back(row(0, 4'b1011, 1, 1, 4'b1111, 0, 1, 0));
    tbl.push_back(row(0, 4'b1011, 1, 1, 4'b1011, 2, 1, 0));
    tbl.push_back(row(0, 4'b1011, 0, 1, 4'b1011, 2, 0, 0));
    tbl.push_back(row(0, 4'b1111, 0, 0, 4'b1011, 2, 0, 0));
    tbl.push_back(row(0, 4'b1111, 0, 0, 4'b1011, 2, 0, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1111, 2, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));
    // rows 11..: starting with slot 1 granted after a timeout
    tbl.push_back(row(0, 4'b1101, 0, 1, 4'b1101, 1, 0, 0));
    tbl.push_back(row(0, 4'b1001, 0, 0, 4'b1111, 1, 0, 0));
    tbl.push_back(row(0, 4'b1001, 0, 0, 4'b1111, 1, 0, 0));
    tbl.push_back(row(0, 4'b1011, 1, 1, 4'b1111, 1, 1, 0));
    tbl.push_back(row(0, 4'b1011, 1, 1, 4'b1011, 2, 1, 0));
    tbl.push_back(row(0, 4'b1101, 1, 1, 4'b1111, 2, 1, 0));
    tbl.push_back(row(0, 4'b1101, 1, 1, 4'b1101, 1, 1, 0));
    tbl.push_back(row(0, 4'b1101, 0, 0, 4'b1101, 1, 0, 0));
    tbl.push_back(row(1, 4'b1101, 0, 0, 4'b1111, 0, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));
    tbl.push_back(row(0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0));

    run_rows(0, 10);

    // round robin with all four requesting: order 1,2,3,0,1
    order = '{1, 2, 3, 0, 1};
    one = 4'b0001;
    drive(0, 4'b0001, 1, 1); step(); check("rr_dead0", 4'b1111, 0, 1, 0);
    drive(0, 4'b0000, 1, 1); step();
    for (int n = 0; n < 5; n++) begin
      eg = ~(one << order[n]);
      check($sformatf("rr_grant%0d", n), eg, 3'(order[n]), 1, 0);
      drive(0, 4'b0000, 0, 0); step();
      check($sformatf("rr_busy%0d", n), eg, 3'(order[n]), 0, 0);
      drive(0, 4'b0000, 1, 1); step();
      check($sformatf("rr_dead%0d", n + 1), 4'b1111, 3'(order[n]), 1, 0);
      step();
    end
    check("rr_final", 4'b1011, 2, 1, 0);
    drive(0, 4'b1111, 1, 1); step(); check("rr_release", 4'b1111, 2, 1, 0);
    step(); check("rr_park", 4'b1110, 0, 1, 0);

    // unused grant to slot 3 is revoked after 16 clocks, slot 1 wins next
    drive(0, 4'b0111, 1, 1); step(); check("to_dead", 4'b1111, 0, 1, 0);
    step(); check("to_grant", 4'b0111, 3, 1, 0);
    drive(0, 4'b0101, 1, 1);
    for (int n = 1; n <= 15; n++) begin
      step(); check($sformatf("to_hold%0d", n), 4'b0111, 3, 1, 0);
    end
    step(); check("to_fire", 4'b1111, 3, 1, 1);
    step(); check("to_regrant", 4'b1101, 1, 1, 0);

    run_rows(11, 21);

    // FRAME_n falling on the timeout edge: BUSY wins, no pulse
    drive(0, 4'b0111, 1, 1); step(); check("tf_dead", 4'b1111, 0, 1, 0);
    step(); check("tf_grant", 4'b0111, 3, 1, 0);
    for (int n = 1; n <= 15; n++) step();
    check("tf_hold", 4'b0111, 3, 1, 0);
    drive(0, 4'b0111, 0, 1); step(); check("tf_busy", 4'b0111, 3, 0, 0);
    drive(0, 4'b1111, 1, 1); step(); check("tf_end", 4'b1111, 3, 1, 0);
    step(); check("tf_park", 4'b1110, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
